// File: rtl/agencia_pkg.sv
// Shared weekday type, field widths and business-hour defaults for the
// branch time-keeping blocks.
package agencia_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int DAY_W  = 3;

  localparam int DEF_OPEN_HOUR  = 10;
  localparam int DEF_CLOSE_HOUR = 16;

  typedef enum logic [DAY_W-1:0] {DOM, SEG, TER, QUA, QUI, SEX, SAB} weekday_t;

  // Monday through Friday.
  function automatic logic dia_util(input logic [DAY_W-1:0] d);
    return (d >= SEG) && (d <= SEX);
  endfunction

endpackage

// File: rtl/contador_mod.sv
// Modulo-N counter with enable, saturating synchronous load and carry-out,
// chained carry->enable to build prescaler, minute, hour and day digits.
module contador_mod #(
  parameter int            N         = 60,
  parameter int            W         = 6,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         carry
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign carry = en && (count == LAST);

  // count_next is exported so the parent can look at the upcoming time.
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = (load_val > LAST) ? LAST : load_val;
    end else if (en) begin
      count_next = carry ? '0 : count + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VAL;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/relogio_expediente.sv
// Time-of-day / weekday keeper producing the business-hours flag and the
// opening/closing pulses for the vault alarm and status display.
module relogio_expediente
  import agencia_pkg::*;
#(
  parameter int CYCLES_PER_MIN = 1,
  parameter int OPEN_HOUR      = DEF_OPEN_HOUR,
  parameter int CLOSE_HOUR     = DEF_CLOSE_HOUR
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              run,
  input  logic              load,
  input  logic [HOUR_W-1:0] load_hour,
  input  logic [MIN_W-1:0]  load_min,
  input  logic [DAY_W-1:0]  load_day,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [DAY_W-1:0]  day,
  output logic              expediente,
  output logic              min_tick,
  output logic              open_pulse,
  output logic              close_pulse
);

  localparam int PRE_W = (CYCLES_PER_MIN > 1) ? $clog2(CYCLES_PER_MIN) : 1;
  localparam logic [HOUR_W-1:0] OPEN_H  = HOUR_W'(OPEN_HOUR);
  localparam logic [HOUR_W-1:0] CLOSE_H = HOUR_W'(CLOSE_HOUR);

  logic [PRE_W-1:0]  pre_count, pre_next;
  logic [MIN_W-1:0]  min_next;
  logic [HOUR_W-1:0] hour_next;
  logic [DAY_W-1:0]  day_next;
  logic              pre_carry, min_carry, hour_carry, day_carry;
  logic              exp_reg, exp_next;

  contador_mod #(.N(CYCLES_PER_MIN), .W(PRE_W), .RESET_VAL('0)) u_pre (
    .clk(clk_2), .reset(reset), .en(run), .load(load), .load_val(PRE_W'(0)),
    .count(pre_count), .count_next(pre_next), .carry(pre_carry)
  );

  contador_mod #(.N(60), .W(MIN_W), .RESET_VAL('0)) u_min (
    .clk(clk_2), .reset(reset), .en(pre_carry), .load(load), .load_val(load_min),
    .count(minute), .count_next(min_next), .carry(min_carry)
  );

  contador_mod #(.N(24), .W(HOUR_W), .RESET_VAL('0)) u_hour (
    .clk(clk_2), .reset(reset), .en(min_carry), .load(load), .load_val(load_hour),
    .count(hour), .count_next(hour_next), .carry(hour_carry)
  );

  contador_mod #(.N(7), .W(DAY_W), .RESET_VAL(DAY_W'(SEG))) u_day (
    .clk(clk_2), .reset(reset), .en(hour_carry), .load(load), .load_val(load_day),
    .count(day), .count_next(day_next), .carry(day_carry)
  );

  // Counter outputs that nothing in this block consumes.
  logic unused_bits;
  assign unused_bits = ^{pre_count, pre_next, min_next, day_carry};

  // Evaluated on the upcoming time so the flag lines up with hour/day.
  assign exp_next = dia_util(day_next) && (hour_next >= OPEN_H) && (hour_next < CLOSE_H);

  always_ff @(posedge clk_2) begin
    if (reset) begin
      exp_reg     <= 1'b0;
      min_tick    <= 1'b0;
      open_pulse  <= 1'b0;
      close_pulse <= 1'b0;
    end else begin
      exp_reg     <= exp_next;
      min_tick    <= pre_carry && !load;
      open_pulse  <= exp_next && !exp_reg;
      close_pulse <= !exp_next && exp_reg;
    end
  end

  assign expediente = exp_reg;

endmodule

// File: tb/tb_relogio_expediente.sv
// Bench for relogio_expediente: vector table, multi-cycle corner sequences
// and a randomized run against a minutes-of-week reference model.
module tb_relogio_expediente;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       run   = 1'b0;
  logic       load  = 1'b0;
  logic [4:0] load_hour = '0;
  logic [5:0] load_min  = '0;
  logic [2:0] load_day  = '0;

  logic [4:0] hour_a, hour_b;
  logic [5:0] minute_a, minute_b;
  logic [2:0] day_a, day_b;
  logic       exp_a, exp_b, tick_a, tick_b, op_a, op_b, cl_a, cl_b;

  always #5 clk_2 = ~clk_2;

  relogio_expediente #(.CYCLES_PER_MIN(1), .OPEN_HOUR(10), .CLOSE_HOUR(16)) dut (
    .clk_2(clk_2), .reset(reset), .run(run), .load(load),
    .load_hour(load_hour), .load_min(load_min), .load_day(load_day),
    .hour(hour_a), .minute(minute_a), .day(day_a), .expediente(exp_a),
    .min_tick(tick_a), .open_pulse(op_a), .close_pulse(cl_a)
  );

  relogio_expediente #(.CYCLES_PER_MIN(3), .OPEN_HOUR(10), .CLOSE_HOUR(16)) dut3 (
    .clk_2(clk_2), .reset(reset), .run(run), .load(load),
    .load_hour(load_hour), .load_min(load_min), .load_day(load_day),
    .hour(hour_b), .minute(minute_b), .day(day_b), .expediente(exp_b),
    .min_tick(tick_b), .open_pulse(op_b), .close_pulse(cl_b)
  );

  int tests = 0;
  int fails = 0;

  logic [17:0] obs_a, obs_b;
  assign obs_a = {hour_a, minute_a, day_a, exp_a, tick_a, op_a, cl_a};
  assign obs_b = {hour_b, minute_b, day_b, exp_b, tick_b, op_b, cl_b};

  function automatic logic [17:0] pack(input int h, input int m, input int d,
                                       input bit e, input bit t, input bit o, input bit c);
    return {5'(h), 6'(m), 3'(d), e, t, o, c};
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d:%0d day%0d exp=%0b tick=%0b open=%0b close=%0b, want %0d:%0d day%0d exp=%0b tick=%0b open=%0b close=%0b",
               name, got[17:13], got[12:7], got[6:4], got[3], got[2], got[1], got[0],
               want[17:13], want[12:7], want[6:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic cycle();
    @(posedge clk_2);
    #1;
  endtask

  task automatic drive(input bit r, input bit rn, input bit ld, input int lh, input int lm, input int lday);
    reset = r; run = rn; load = ld;
    load_hour = 5'(lh); load_min = 6'(lm); load_day = 3'(lday);
  endtask

  // Reference model: time as minutes since Sunday 00:00, stepped per edge.
  int m_t[2];
  int m_pc[2];
  bit m_exp[2], m_tick[2], m_op[2], m_cl[2];

  function automatic bit biz(input int t);
    int d, h;
    d = t / 1440;
    h = (t % 1440) / 60;
    return (d >= 1) && (d <= 5) && (h >= 10) && (h < 16);
  endfunction

  always @(posedge clk_2) begin : model
    int c, nt, npc, lh, lm, ld;
    bit ne, nk;
    for (int i = 0; i < 2; i++) begin
      c = (i == 0) ? 1 : 3;
      nt = m_t[i]; npc = m_pc[i]; nk = 1'b0;
      if (reset) begin
        m_t[i] <= 1440; m_pc[i] <= 0;
        m_exp[i] <= 1'b0; m_tick[i] <= 1'b0; m_op[i] <= 1'b0; m_cl[i] <= 1'b0;
      end else begin
        if (load) begin
          lh = (load_hour > 23) ? 23 : int'(load_hour);
          lm = (load_min > 59) ? 59 : int'(load_min);
          ld = (load_day > 6) ? 6 : int'(load_day);
          nt = ld * 1440 + lh * 60 + lm;
          npc = 0;
        end else if (run) begin
          if (npc == c - 1) begin
            npc = 0;
            nt = (nt + 1) % 10080;
            nk = 1'b1;
          end else begin
            npc = npc + 1;
          end
        end
        ne = biz(nt);
        m_t[i] <= nt; m_pc[i] <= npc; m_tick[i] <= nk;
        m_op[i] <= ne && !m_exp[i];
        m_cl[i] <= !ne && m_exp[i];
        m_exp[i] <= ne;
      end
    end
  end

  function automatic logic [17:0] model_obs(input int i);
    return pack((m_t[i] % 1440) / 60, m_t[i] % 60, m_t[i] / 1440,
                m_exp[i], m_tick[i], m_op[i], m_cl[i]);
  endfunction

  typedef struct {
    bit rst, rn, ld;
    int lh, lm, lday;
    int eh, em, ed;
    bit ee, et, eo, ec;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int ticks, opens, open_cycle;
    bit tick_want[4];

    vecs[0]  = '{1, 0, 0,  0,  0, 0,   0,  0, 1,  0, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 15, 59, 5,  15, 59, 5,  1, 0, 1, 0};
    vecs[2]  = '{0, 1, 0,  0,  0, 0,  16,  0, 5,  0, 1, 0, 1};
    vecs[3]  = '{0, 0, 0,  0,  0, 0,  16,  0, 5,  0, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 23, 59, 6,  23, 59, 6,  0, 0, 0, 0};
    vecs[5]  = '{0, 1, 0,  0,  0, 0,   0,  0, 0,  0, 1, 0, 0};
    vecs[6]  = '{0, 0, 1, 30, 63, 7,  23, 59, 6,  0, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 11,  0, 3,  11,  0, 3,  1, 0, 1, 0};
    vecs[8]  = '{0, 1, 1, 11,  0, 3,  11,  0, 3,  1, 0, 0, 0};
    vecs[9]  = '{1, 1, 1, 12,  0, 2,   0,  0, 1,  0, 0, 0, 0};
    vecs[10] = '{0, 0, 1,  9, 59, 1,   9, 59, 1,  0, 0, 0, 0};
    vecs[11] = '{0, 1, 0,  0,  0, 0,  10,  0, 1,  1, 1, 1, 0};
    vecs[12] = '{0, 1, 0,  0,  0, 0,  10,  1, 1,  1, 1, 0, 0};
    vecs[13] = '{0, 0, 1, 10,  0, 0,  10,  0, 0,  0, 0, 0, 1};
    vecs[14] = '{0, 0, 1, 10,  0, 1,  10,  0, 1,  1, 0, 1, 0};
    vecs[15] = '{0, 0, 0,  0,  0, 0,  10,  0, 1,  1, 0, 0, 0};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].rn, vecs[i].ld, vecs[i].lh, vecs[i].lm, vecs[i].lday);
      cycle();
      check($sformatf("vec%0d", i), obs_a,
            pack(vecs[i].eh, vecs[i].em, vecs[i].ed, vecs[i].ee, vecs[i].et, vecs[i].eo, vecs[i].ec));
    end

    // 600 minutes from Monday 00:00 reaches opening time.
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 1, 0, 0, 0, 0);
    ticks = 0; opens = 0; open_cycle = -1;
    for (int n = 1; n <= 600; n++) begin
      cycle();
      if (tick_a) ticks++;
      if (op_a) begin
        opens++;
        open_cycle = n;
      end
    end
    check_int("run600_ticks", ticks, 600);
    check_int("run600_opens", opens, 1);
    check_int("run600_open_cycle", open_cycle, 600);
    check("run600_final", obs_a, pack(10, 0, 1, 1, 1, 1, 0));

    // Three-cycle prescaler: advance only on the third run-high cycle.
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    tick_want = '{0, 0, 0, 1};
    for (int n = 0; n < 4; n++) begin
      drive(0, (n != 1), 0, 0, 0, 0);
      cycle();
      check_int($sformatf("cpm3_tick%0d", n), int'(tick_b), int'(tick_want[n]));
    end
    check("cpm3_after", obs_b, pack(0, 1, 1, 0, 1, 0, 0));

    // Load coinciding with terminal count: load wins, prescaler restarts.
    drive(0, 1, 0, 0, 0, 0);
    cycle();
    cycle();
    drive(0, 1, 1, 12, 0, 2);
    cycle();
    check("cpm3_load_wins", obs_b, pack(12, 0, 2, 1, 0, 1, 0));
    drive(0, 1, 0, 0, 0, 0);
    cycle();
    check("cpm3_restart1", obs_b, pack(12, 0, 2, 1, 0, 0, 0));
    cycle();
    check("cpm3_restart2", obs_b, pack(12, 0, 2, 1, 0, 0, 0));
    cycle();
    check("cpm3_restart3", obs_b, pack(12, 1, 2, 1, 1, 0, 0));

    // Randomized traffic, both instances against the model.
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        drive(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
      end else if ($urandom_range(0, 15) == 0) begin
        drive(0, $urandom_range(0, 1), 1, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 7));
      end else begin
        drive(0, ($urandom_range(0, 3) != 0), 0, 0, 0, 0);
      end
      // Bias toward business-hour boundaries now and then.
      if (load && $urandom_range(0, 1) == 1) begin
        load_hour = ($urandom_range(0, 1) == 1) ? 5'd9 : 5'd15;
        load_min  = 6'd58;
      end
      cycle();
      check($sformatf("rand_a%0d", n), obs_a, model_obs(0));
      check($sformatf("rand_b%0d", n), obs_b, model_obs(1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/relogio_expediente.md
# relogio_expediente

Time-of-day and weekday keeper that produces the business-hours flag consumed by the vault alarm logic as its `relogio` input. Counts minutes, hours and weekdays from a prescaled `clk_2`, accepts a synchronous time load, and flags business hours (Mon–Fri, OPEN_HOUR:00 up to but excluding CLOSE_HOUR:00). Also emits one-cycle pulses at opening and closing for the LED/LCD status path.

## Interface
- CYCLES_PER_MIN, default 1: `clk_2` cycles per simulated minute (≥1).
- OPEN_HOUR, default 10: first business hour (0–23).
- CLOSE_HOUR, default 16: first hour after business (OPEN_HOUR < CLOSE_HOUR ≤ 23).

- clk_2  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  1 = time advances; 0 = time frozen (prescaler holds).
- load  in  1  1 = overwrite time with load_* this edge.
- load_hour  in  5  hour to load, 0–23.
- load_min  in  6  minute to load, 0–59.
- load_day  in  3  weekday to load, 0 = Sunday … 6 = Saturday.
- hour  out  5  current hour.
- minute  out  6  current minute.
- day  out  3  current weekday.
- expediente  out  1  1 = business hours now.
- min_tick  out  1  one-cycle pulse on each minute advance.
- open_pulse  out  1  one-cycle pulse when expediente goes 0→1.
- close_pulse  out  1  one-cycle pulse when expediente goes 1→0.

## Operation
- Reset values: hour 0, minute 0, day 1 (Monday), prescaler 0, expediente 0, min_tick 0, open_pulse 0, close_pulse 0.
- Priority per edge: reset > load > run > hold.
- Prescaler counts 0..CYCLES_PER_MIN−1 while run=1; on terminal count it wraps to 0 and a minute advance occurs. With CYCLES_PER_MIN=1 every run cycle advances one minute.
- Minute advance: minute 59→0 carries to hour; hour 23→0 carries to day; day 6→0. Carries are ripple within the same edge (23:59 Sat → 00:00 Sun in one step).
- Load: hour/minute/day take load_* values and the prescaler clears to 0. Out-of-range values saturate: hour>23 → 23, minute>59 → 59, day 7 → 6. Load never raises min_tick.
- expediente is registered and computed from the next-state time, so it is always consistent with hour/minute/day in the same cycle: 1 iff day∈{1..5} and OPEN_HOUR ≤ hour < CLOSE_HOUR.
- open_pulse/close_pulse: asserted for the cycle in which the registered expediente differs from its previous value, whether the change came from counting or from load. Reset never produces a pulse.
- run=0 freezes all time state; expediente holds; pulses are 0.

## Timing
- min_tick is high in the same cycle in which the new minute value is visible on `minute`.
- Latency from load asserted to new time and expediente visible: 1 edge.
- Simultaneous load and terminal prescaler count: load wins, no tick, no advance.
- Reset asserted mid-count: all outputs reach reset values after that edge regardless of run/load.
- Every output is a flop output; there are no combinational input-to-output paths.

## Structure
- Shared package `agencia_pkg`: weekday enum (DOM, SEG, TER, QUA, QUI, SEX, SAB), widths HOUR_W=5, MIN_W=6, DAY_W=3, and default OPEN_HOUR/CLOSE_HOUR constants.
- One sub-module `contador_mod`: parameterised modulo-N counter with enable, synchronous load, saturating load value and carry-out. Instantiated for the prescaler, minutes, hours and days, chained through carry→enable.
- The top-level owns the expediente compare, the previous-value flop and pulse generation.

## Test plan
- Reset then run=1 for 600 cycles (CYCLES_PER_MIN=1): time 10:00 Mon, expediente rises on that cycle, open_pulse exactly once, 600 min_tick pulses.
- Load 15:59 Fri, run one cycle: time 16:00, expediente 1→0, close_pulse for one cycle.
- Load 23:59 Sat, run one cycle: time 00:00 Sun, min_tick=1, expediente stays 0, no pulses.
- CYCLES_PER_MIN=3, run toggling 1,0,1,1: exactly one minute advance, after the 3rd run-high cycle.
- Load hour=30, min=63, day=7: reads 23:59 Sat; then load 11:00 Wed: expediente 1 next cycle with open_pulse, no min_tick.
- Reset asserted together with load at 12:00 Tue: outputs 00:00 Mon, expediente 0, no pulses.
